// File: rtl/ps2_pkg.sv
// Shared types and scan-code constants for the PS/2 keyboard front end.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam logic [7:0] SC_BREAK    = 8'hF0;
  localparam logic [7:0] SC_EXT      = 8'hE0;
  localparam logic [7:0] SC_LSHIFT   = 8'h12;
  localparam logic [7:0] SC_RSHIFT   = 8'h59;
  localparam logic [7:0] SC_CAPS     = 8'h58;
  localparam logic [7:0] SC_KP_ENTER = 8'h5A;

endpackage

// File: rtl/ps2_scan2ascii.sv
// Combinational scan-code set 2 to ASCII map; 0 means the code has no printable mapping.
module ps2_scan2ascii (
  input  logic [7:0] code,
  input  logic       shift,
  input  logic       caps,
  output logic [7:0] ascii
);

  logic [7:0] lo;
  logic [7:0] hi;
  logic       letter;

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    lo = 8'h00;
    hi = 8'h00;
    case (code)
      8'h1C: lo = "a";  8'h32: lo = "b";  8'h21: lo = "c";  8'h23: lo = "d";
      8'h24: lo = "e";  8'h2B: lo = "f";  8'h34: lo = "g";  8'h33: lo = "h";
      8'h43: lo = "i";  8'h3B: lo = "j";  8'h42: lo = "k";  8'h4B: lo = "l";
      8'h3A: lo = "m";  8'h31: lo = "n";  8'h44: lo = "o";  8'h4D: lo = "p";
      8'h15: lo = "q";  8'h2D: lo = "r";  8'h1B: lo = "s";  8'h2C: lo = "t";
      8'h3C: lo = "u";  8'h2A: lo = "v";  8'h1D: lo = "w";  8'h22: lo = "x";
      8'h35: lo = "y";  8'h1A: lo = "z";
      8'h16: begin lo = "1"; hi = "!"; end
      8'h1E: begin lo = "2"; hi = "@"; end
      8'h26: begin lo = "3"; hi = "#"; end
      8'h25: begin lo = "4"; hi = "$"; end
      8'h2E: begin lo = "5"; hi = "%"; end
      8'h36: begin lo = "6"; hi = "^"; end
      8'h3D: begin lo = "7"; hi = "&"; end
      8'h3E: begin lo = "8"; hi = "*"; end
      8'h46: begin lo = "9"; hi = "("; end
      8'h45: begin lo = "0"; hi = ")"; end
      8'h0E: begin lo = 8'h60; hi = "~"; end
      8'h4E: begin lo = "-"; hi = "_"; end
      8'h55: begin lo = "="; hi = "+"; end
      8'h54: begin lo = "["; hi = "{"; end
      8'h5B: begin lo = "]"; hi = "}"; end
      8'h5D: begin lo = 8'h5C; hi = "|"; end
      8'h4C: begin lo = ";"; hi = ":"; end
      8'h52: begin lo = 8'h27; hi = 8'h22; end
      8'h41: begin lo = ","; hi = "<"; end
      8'h49: begin lo = "."; hi = ">"; end
      8'h4A: begin lo = "/"; hi = "?"; end
      8'h29: begin lo = " "; hi = " "; end
      8'h5A: begin lo = 8'h0D; hi = 8'h0D; end
      8'h66: begin lo = 8'h08; hi = 8'h08; end
      8'h0D: begin lo = 8'h09; hi = 8'h09; end
      8'h76: begin lo = 8'h1B; hi = 8'h1B; end
      default: ;
    endcase
  end

  // Letters share one case arm; their upper-case form is the lower case with bit 5 cleared.
  assign letter = (lo >= "a") && (lo <= "z");
  assign ascii  = letter ? (((shift ^ caps) ? (lo ^ 8'h20) : lo))
                         : (shift ? hi : lo);

endmodule

// File: rtl/ps2_ascii_decoder.sv
// PS/2 receiver plus key layer: frames in, held-key ASCII, shift and caps-lock state out.
module ps2_ascii_decoder
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 200_000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] ascii_key,
  output logic [7:0] scan_code,
  output logic       byte_valid,
  output logic       key_event,
  output logic       shift_held,
  output logic       caps_lock,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);

  logic [SYNC_STAGES-1:0] clk_sync, data_sync;
  logic                   clk_prev, fall, bit_in;
  rx_state_t              state, state_next;
  logic [2:0]             bit_cnt;
  logic [7:0]             shreg;
  logic                   par_bit;
  logic [TW-1:0]          to_cnt;
  logic                   timeout, shift_en, par_load, accept, bad;
  logic                   brk_flag, ext_flag, lshift, rshift, caps_held;
  logic [8:0]             cur_code;
  logic [7:0]             mapped;

  // Synchronisers reset to the idle-high line level so reset never fakes a falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
      clk_prev  <= clk_sync[SYNC_STAGES-1];
    end
  end

  assign fall    = clk_prev & ~clk_sync[SYNC_STAGES-1];
  assign bit_in  = data_sync[SYNC_STAGES-1];
  assign timeout = (state != IDLE) && !fall && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    shift_en   = 1'b0;
    par_load   = 1'b0;
    accept     = 1'b0;
    bad        = 1'b0;
    if (fall) begin
      case (state)
        IDLE:   if (!bit_in) state_next = DATA; else bad = 1'b1;
        DATA: begin
          shift_en = 1'b1;
          if (bit_cnt == 3'd7) state_next = PARITY;
        end
        PARITY: begin
          par_load   = 1'b1;
          state_next = STOP;
        end
        STOP: begin
          state_next = IDLE;
          if (bit_in && (^{shreg, par_bit})) accept = 1'b1;
          else                               bad    = 1'b1;
        end
        default: state_next = IDLE;
      endcase
    end else if (timeout) begin
      state_next = IDLE;
      bad        = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt    <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      to_cnt     <= '0;
      scan_code  <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      if (state == IDLE)  bit_cnt <= '0;
      else if (shift_en)  bit_cnt <= bit_cnt + 3'd1;
      if (shift_en)       shreg   <= {bit_in, shreg[7:1]};
      if (par_load)       par_bit <= bit_in;
      if ((state == IDLE) || fall || timeout) to_cnt <= '0;
      else                                    to_cnt <= to_cnt + 1'b1;
      if (accept) scan_code <= shreg;
      byte_valid <= accept;
      frame_err  <= bad;
    end
  end

  ps2_scan2ascii u_map (
    .code  (scan_code),
    .shift (shift_held),
    .caps  (caps_lock),
    .ascii (mapped)
  );

  assign shift_held = lshift | rshift;

  // cur_code carries the E0 prefix in bit 8 so keypad enter and main enter release independently.
  always_ff @(posedge clk) begin
    if (rst) begin
      ascii_key <= '0;
      key_event <= 1'b0;
      brk_flag  <= 1'b0;
      ext_flag  <= 1'b0;
      lshift    <= 1'b0;
      rshift    <= 1'b0;
      caps_lock <= 1'b0;
      caps_held <= 1'b0;
      cur_code  <= '0;
    end else begin
      key_event <= 1'b0;
      if (byte_valid) begin
        if (scan_code == SC_BREAK)     brk_flag <= 1'b1;
        else if (scan_code == SC_EXT)  ext_flag <= 1'b1;
        else begin
          brk_flag <= 1'b0;
          ext_flag <= 1'b0;
          if (ext_flag) begin
            if (scan_code == SC_KP_ENTER) begin
              if (brk_flag) begin
                if (cur_code == {1'b1, scan_code}) ascii_key <= '0;
              end else begin
                ascii_key <= 8'h0D;
                cur_code  <= {1'b1, scan_code};
                key_event <= 1'b1;
              end
            end
          end else if (brk_flag) begin
            if (scan_code == SC_LSHIFT) lshift    <= 1'b0;
            if (scan_code == SC_RSHIFT) rshift    <= 1'b0;
            if (scan_code == SC_CAPS)   caps_held <= 1'b0;
            if (cur_code == {1'b0, scan_code}) ascii_key <= '0;
          end else begin
            if (scan_code == SC_LSHIFT) lshift <= 1'b1;
            if (scan_code == SC_RSHIFT) rshift <= 1'b1;
            if ((scan_code == SC_CAPS) && !caps_held) begin
              caps_lock <= ~caps_lock;
              caps_held <= 1'b1;
            end
            if (mapped != 8'h00) begin
              ascii_key <= mapped;
              cur_code  <= {1'b0, scan_code};
              key_event <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule
